// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box and Rcon tables, word/block types, expander state enum.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_KEYS   = NUM_ROUNDS + 1;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned SCHED_W    = BLOCK_W * NUM_KEYS;
  localparam int unsigned ROUND_W    = 4;

  typedef logic [0:WORD_W-1]  word_t;
  typedef logic [0:BLOCK_W-1] block_t;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  // Forward S-box, entry i at bits [8i : 8i+7].
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon[1..10], entry r at bits [8(r-1) : 8(r-1)+7].
  localparam logic [0:79] RCON_TABLE = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX_TABLE[11'(b) * 11'd8 +: 8];
  endfunction

  function automatic logic [7:0] rcon_lookup(input logic [ROUND_W-1:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    if (r >= 4'd1 && r <= 4'(NUM_ROUNDS))
      rc = RCON_TABLE[(7'(r) - 7'd1) * 7'd8 +: 8];
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst_c
);

  assign subst_c = sbox_lookup(data);

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key expansion: one round key per clock into a held 11-key schedule.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [0:127]   key,
  input  logic           key_valid,
  output logic [0:1407]  schedule,
  output logic           sched_valid,
  output logic           busy
);

  state_t               state;
  logic [ROUND_W-1:0]   round;
  block_t               work;

  word_t w0, w1, w2, w3;
  word_t rot_w, sub_w, t_w;
  word_t n0, n1, n2, n3;
  block_t next_blk;

  assign w0 = work[0:31];
  assign w1 = work[32:63];
  assign w2 = work[64:95];
  assign w3 = work[96:127];

  assign rot_w = {w3[8:31], w3[0:7]};

  // SubWord: four parallel S-box lookups on the rotated last word.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data    (rot_w[8*i +: 8]),
      .subst_c (sub_w[8*i +: 8])
    );
  end

  assign t_w      = sub_w ^ {rcon_lookup(round), 24'h000000};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_blk = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      round       <= '0;
      work        <= '0;
      schedule    <= '0;
      sched_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (key_valid) begin
            schedule[0:127] <= key;
            work            <= key;
            round           <= 4'd1;
            sched_valid     <= 1'b0;
            busy            <= 1'b1;
            state           <= EXPAND;
          end
        end
        EXPAND: begin
          // Slot index is the round counter; key_valid is ignored here.
          for (int unsigned r = 1; r <= NUM_ROUNDS; r++) begin
            if (round == 4'(r))
              schedule[r*BLOCK_W +: BLOCK_W] <= next_blk;
          end
          work <= next_blk;
          if (round == 4'(NUM_ROUNDS)) begin
            busy        <= 1'b0;
            sched_valid <= 1'b1;
            state       <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: begin
          state       <= IDLE;
          round       <= '0;
          sched_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander with a schedule scoreboard and FIPS-197 vectors.
module tb_aes_key_expander;
  import aes_pkg::*;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic [0:127]  key;
  logic          key_valid;
  logic [0:1407] schedule;
  logic          sched_valid;
  logic          busy;

  aes_key_expander dut (
    .clk         (tb_clk),
    .rst         (rst),
    .key         (key),
    .key_valid   (key_valid),
    .schedule    (schedule),
    .sched_valid (sched_valid),
    .busy        (busy)
  );

  always #5 tb_clk = ~tb_clk;

  localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:1407] FIPS_SCHED = {
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:1407] sb_q[$];

  // On mismatch, report the first differing 128-bit slot (slot 10 holds small scalars).
  task automatic check(input string tag, input logic [1407:0] obs, input logic [1407:0] exp);
    logic [1407:0] diff;
    int slot;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      diff = obs ^ exp;
      slot = 10;
      for (int s = 10; s >= 0; s--)
        if (diff[1407-128*s -: 128] != '0) slot = s;
      $display("FAIL %s: slot %0d got %h want %h", tag, slot,
               obs[1407-128*slot -: 128], exp[1407-128*slot -: 128]);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  // Word-array form of the expansion with Rcon generated by xtime.
  function automatic logic [0:1407] ref_expand(input logic [0:127] k);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [0:1407] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_lookup(tmp[31:24]), sbox_lookup(tmp[23:16]),
               sbox_lookup(tmp[15:8]),  sbox_lookup(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic start(input string tag, input logic [0:127] k, input bit hold);
    key       = k;
    key_valid = 1'b1;
    sb_q.push_back(ref_expand(k));
    step();
    if (!hold) key_valid = 1'b0;
    check({tag, "_accept_sv"}, 1408'(sched_valid), 1408'(0));
    check({tag, "_accept_busy"}, 1408'(busy), 1408'(1));
  endtask

  // Waits for sched_valid; optionally pulses key_valid with p_key during loop cycles [p_lo, p_hi).
  task automatic wait_done(input string tag, input int p_lo, input int p_hi, input logic [0:127] p_key);
    int n;
    int bc;
    logic [0:1407] exp;
    n  = 0;
    bc = busy ? 1 : 0;
    while (!sched_valid && n < 20) begin
      if (p_hi > p_lo) begin
        if (n >= p_lo && n < p_hi) begin
          key_valid = 1'b1;
          key       = p_key;
        end else begin
          key_valid = 1'b0;
        end
      end
      step();
      n++;
      if (busy) bc++;
    end
    check({tag, "_latency"}, 1408'(n), 1408'(10));
    check({tag, "_busy_cycles"}, 1408'(bc), 1408'(10));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1408'(0), 1408'(1));
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_schedule"}, schedule, exp);
    end
  endtask

  initial begin
    logic [0:127] ka, kb, kc;
    rst       = 1'b1;
    key       = '0;
    key_valid = 1'b0;
    step();
    step();
    check("rst_schedule", schedule, '0);
    check("rst_sv", 1408'(sched_valid), 1408'(0));
    check("rst_busy", 1408'(busy), 1408'(0));
    rst = 1'b0;
    step();

    // FIPS-197 reference key
    start("fips", FIPS_KEY, 1'b0);
    wait_done("fips", 0, 0, '0);
    check("fips_full", schedule, FIPS_SCHED);
    check("fips_rk1", 1408'(schedule[128:255]), 1408'(128'ha0fafe1788542cb123a339392a6c7605));
    check("fips_rk10", 1408'(schedule[1280:1407]), 1408'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // Key wiggling without key_valid must not disturb a held schedule
    for (int i = 0; i < 3; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    check("hold_schedule", schedule, FIPS_SCHED);
    check("hold_sv", 1408'(sched_valid), 1408'(1));

    // Restart from DONE with all-zero key
    start("zero", '0, 1'b0);
    wait_done("zero", 0, 0, '0);
    check("zero_rk1", 1408'(schedule[128:255]), 1408'(128'h62636363626363636263636362636363));
    check("zero_rk10", 1408'(schedule[1280:1407]), 1408'(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

    // key_valid with another key during EXPAND is ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    start("ignore", ka, 1'b0);
    wait_done("ignore", 2, 7, kb);
    key_valid = 1'b0;

    // key_valid held high: restarts each time DONE is reached
    kc = {$urandom, $urandom, $urandom, $urandom};
    start("held", kc, 1'b1);
    wait_done("held1", 0, 0, '0);
    sb_q.push_back(ref_expand(kc));
    step();
    check("held_restart_sv", 1408'(sched_valid), 1408'(0));
    check("held_restart_busy", 1408'(busy), 1408'(1));
    wait_done("held2", 0, 0, '0);
    key_valid = 1'b0;
    step();
    check("held_stop_sv", 1408'(sched_valid), 1408'(1));

    // Reset mid-expansion, with a simultaneous key_valid
    start("midrst", FIPS_KEY, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst       = 1'b1;
    key_valid = 1'b1;
    step();
    rst       = 1'b0;
    key_valid = 1'b0;
    check("midrst_schedule", schedule, '0);
    check("midrst_sv", 1408'(sched_valid), 1408'(0));
    check("midrst_busy", 1408'(busy), 1408'(0));
    void'(sb_q.pop_back());
    step();
    check("midrst_idle_busy", 1408'(busy), 1408'(0));
    start("after_rst", FIPS_KEY, 1'b0);
    wait_done("after_rst", 0, 0, '0);
    check("after_rst_full", schedule, FIPS_SCHED);

    check("sb_drained", 1408'(sb_q.size()), 1408'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
